// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC owner and single-outstanding-request instruction fetch stage
// Rev 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic        req_q;
  logic        kill_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic        valid_q;

  logic [31:0] target_w;
  logic [31:0] pc_plus4_w;
  logic [31:0] redirect_pc_w;

  assign target_w      = branch_target_i & ~32'h0000_0003;
  assign pc_plus4_w    = pc_q + 32'd4;
  assign redirect_pc_w = branch_i ? target_w : pc_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      req_q      <= 1'b0;
      kill_q     <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_out_q   <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (branch_i) pc_q <= target_w;
          if (start_i) begin
            req_addr_q <= redirect_pc_w;
            req_q      <= 1'b1;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            if (kill_q || branch_i) begin
              // Wrong-path word: drop it and re-request at the redirected PC.
              kill_q     <= 1'b0;
              pc_q       <= redirect_pc_w;
              req_addr_q <= redirect_pc_w;
            end else begin
              instr_q  <= mem_data_i;
              pc_out_q <= req_addr_q;
              valid_q  <= 1'b1;
              req_q    <= 1'b0;
              state_q  <= S_HOLD;
            end
          end else if (branch_i) begin
            pc_q   <= target_w;
            kill_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (branch_i) begin
            pc_q       <= target_w;
            req_addr_q <= target_w;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_out_q   <= 32'h0;
            req_q      <= 1'b1;
            state_q    <= S_REQ;
          end else if (!stall_i) begin
            pc_q       <= pc_plus4_w;
            req_addr_q <= pc_plus4_w;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_out_q   <= 32'h0;
            req_q      <= 1'b1;
            state_q    <= S_REQ;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o  = req_q;
  assign mem_addr_o = req_addr_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_out_q;
  assign valid_o    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Rev 1.0
// ============================================================================
module tb_fetch_unit;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instance A: default parameters
  logic        a_rst, a_start, a_stall, a_br, a_ack;
  logic [31:0] a_tgt, a_mdata;
  logic        a_req, a_valid;
  logic [31:0] a_addr, a_instr, a_pc;

  // Instance B: PC at the top of the address space, non-zero NOP
  logic        b_rst, b_start, b_stall, b_br, b_ack;
  logic [31:0] b_tgt, b_mdata;
  logic        b_req, b_valid;
  logic [31:0] b_addr, b_instr, b_pc;

  fetch_unit u_dut_a (
    .clk_i(clk_i), .rst_i(a_rst), .start_i(a_start), .stall_i(a_stall),
    .branch_i(a_br), .branch_target_i(a_tgt), .mem_req_o(a_req),
    .mem_addr_o(a_addr), .mem_ack_i(a_ack), .mem_data_i(a_mdata),
    .instr_o(a_instr), .pc_o(a_pc), .valid_o(a_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) u_dut_b (
    .clk_i(clk_i), .rst_i(b_rst), .start_i(b_start), .stall_i(b_stall),
    .branch_i(b_br), .branch_target_i(b_tgt), .mem_req_o(b_req),
    .mem_addr_o(b_addr), .mem_ack_i(b_ack), .mem_data_i(b_mdata),
    .instr_o(b_instr), .pc_o(b_pc), .valid_o(b_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    a_rst = 0; a_start = 0; a_stall = 0; a_br = 0; a_ack = 0; a_tgt = 0; a_mdata = 0;
    b_rst = 0; b_start = 0; b_stall = 0; b_br = 0; b_ack = 0; b_tgt = 0; b_mdata = 0;
    tick(); tick();

    // ---------------- reset state ----------------
    check_eq("a_rst_req",   {31'b0, a_req},   32'h0);
    check_eq("a_rst_addr",  a_addr,           32'h0);
    check_eq("a_rst_valid", {31'b0, a_valid}, 32'h0);
    check_eq("a_rst_instr", a_instr,          32'h0);
    check_eq("a_rst_pc",    a_pc,             32'h0);

    // ---------------- first fetch, zero wait ----------------
    a_rst = 1; tick();
    check_eq("a_idle_req", {31'b0, a_req}, 32'h0);
    a_start = 1; tick(); a_start = 0;
    check_eq("a_req1",      {31'b0, a_req}, 32'h1);
    check_eq("a_req1_addr", a_addr,         32'h0);
    a_ack = 1; a_mdata = 32'h0050_0093; tick(); a_ack = 0;
    check_eq("a_v1_valid", {31'b0, a_valid}, 32'h1);
    check_eq("a_v1_instr", a_instr,          32'h0050_0093);
    check_eq("a_v1_pc",    a_pc,             32'h0);
    check_eq("a_v1_req",   {31'b0, a_req},   32'h0);
    tick();
    check_eq("a_req2",       {31'b0, a_req},   32'h1);
    check_eq("a_req2_addr",  a_addr,           32'h4);
    check_eq("a_req2_valid", {31'b0, a_valid}, 32'h0);
    check_eq("a_req2_instr", a_instr,          32'h0);

    // ---------------- stall held for three cycles ----------------
    a_ack = 1; a_mdata = 32'hAAAA_0001; tick(); a_ack = 0;
    a_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("a_stall_valid", {31'b0, a_valid}, 32'h1);
      check_eq("a_stall_instr", a_instr,          32'hAAAA_0001);
      check_eq("a_stall_pc",    a_pc,             32'h4);
      check_eq("a_stall_req",   {31'b0, a_req},   32'h0);
    end
    a_stall = 0; tick();
    check_eq("a_post_stall_req",  {31'b0, a_req}, 32'h1);
    check_eq("a_post_stall_addr", a_addr,         32'h8);

    // ---------------- branch during a 4-cycle ack wait ----------------
    check_eq("a_w1_addr", a_addr, 32'h8); tick();
    a_br = 1; a_tgt = 32'h40;
    check_eq("a_w2_addr", a_addr, 32'h8); tick();
    a_br = 0;
    check_eq("a_w3_addr", a_addr, 32'h8);
    check_eq("a_w3_req",  {31'b0, a_req}, 32'h1); tick();
    check_eq("a_w4_addr", a_addr, 32'h8); tick();
    a_ack = 1; a_mdata = 32'hDEAD_BEEF;
    check_eq("a_w5_addr", a_addr, 32'h8); tick(); a_ack = 0;
    check_eq("a_kill_valid", {31'b0, a_valid}, 32'h0);
    check_eq("a_kill_req",   {31'b0, a_req},   32'h1);
    check_eq("a_kill_addr",  a_addr,           32'h40);
    a_ack = 1; a_mdata = 32'h0000_1234; tick(); a_ack = 0;
    check_eq("a_br_valid", {31'b0, a_valid}, 32'h1);
    check_eq("a_br_pc",    a_pc,             32'h40);
    check_eq("a_br_instr", a_instr,          32'h0000_1234);
    tick();
    check_eq("a_br_next_addr", a_addr, 32'h44);

    // ---------------- branch together with ack, unaligned target ----------------
    a_ack = 1; a_br = 1; a_tgt = 32'h103; a_mdata = 32'hBADB_AD00; tick();
    a_ack = 0; a_br = 0;
    check_eq("a_brack_valid", {31'b0, a_valid}, 32'h0);
    check_eq("a_brack_req",   {31'b0, a_req},   32'h1);
    check_eq("a_brack_addr",  a_addr,           32'h100);
    a_ack = 1; a_mdata = 32'h5555_5555; tick(); a_ack = 0;
    check_eq("a_brack_pc", a_pc, 32'h100);

    // ---------------- HOLD with branch and stall both set ----------------
    a_br = 1; a_stall = 1; a_tgt = 32'h200; tick();
    a_br = 0; a_stall = 0;
    check_eq("a_hb_valid", {31'b0, a_valid}, 32'h0);
    check_eq("a_hb_instr", a_instr,          32'h0);
    check_eq("a_hb_pc",    a_pc,             32'h0);
    check_eq("a_hb_req",   {31'b0, a_req},   32'h1);
    check_eq("a_hb_addr",  a_addr,           32'h200);

    // ---------------- instance B: wrap and async reset ----------------
    check_eq("b_rst_addr",  b_addr,  32'hFFFF_FFFC);
    check_eq("b_rst_instr", b_instr, 32'h0000_0013);
    b_rst = 1; b_start = 1; tick(); b_start = 0;
    check_eq("b_req1_addr", b_addr, 32'hFFFF_FFFC);
    b_ack = 1; b_mdata = 32'h0000_0011; tick(); b_ack = 0;
    check_eq("b_v1_pc", b_pc, 32'hFFFF_FFFC);
    tick();
    check_eq("b_wrap_addr", b_addr, 32'h0);
    check_eq("b_wrap_instr", b_instr, 32'h0000_0013);
    b_ack = 1; b_mdata = 32'h0000_0022; tick(); b_ack = 0;
    check_eq("b_v2_pc",    b_pc,    32'h0);
    check_eq("b_v2_instr", b_instr, 32'h0000_0022);
    tick();
    check_eq("b_req3_addr", b_addr, 32'h4);
    tick();
    #2 b_rst = 0; #1;
    check_eq("b_arst_req",   {31'b0, b_req},   32'h0);
    check_eq("b_arst_addr",  b_addr,           32'hFFFF_FFFC);
    check_eq("b_arst_valid", {31'b0, b_valid}, 32'h0);
    check_eq("b_arst_instr", b_instr,          32'h0000_0013);
    check_eq("b_arst_pc",    b_pc,             32'h0);

    // Branch in IDLE moves PC only; the next start fetches from there.
    tick(); b_rst = 1;
    b_br = 1; b_tgt = 32'h81; tick(); b_br = 0;
    check_eq("b_idle_br_req", {31'b0, b_req}, 32'h0);
    b_start = 1; tick(); b_start = 0;
    check_eq("b_idle_br_addr", b_addr, 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the program counter and drives instructions into the IF/ID pipeline register. It issues one request at a time to instruction memory over a req/ack handshake and buffers the returned word until IF/ID accepts it. It also redirects on taken branches resolved in ID, discarding any in-flight or buffered wrong-path instruction. `valid_o` low tells IF/ID to load a bubble.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, default 32'h0000_0000: value on `instr_o` whenever `valid_o`=0.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; one clock, asynchronous, active-low.
- `start_i`  in  1  fetch enable; sampled only in IDLE.
- `stall_i`  in  1  IF/ID stall from hazard detection; buffered instruction must be held.
- `branch_i`  in  1  taken-branch redirect from ID; same cycle IF/ID is flushed.
- `branch_target_i`  in  32  redirect PC; bits [1:0] forced to 0.
- `mem_req_o`  out  1  instruction memory request.
- `mem_addr_o`  out  32  request address; stable while `mem_req_o`=1 until ack.
- `mem_ack_i`  in  1  memory returns `mem_data_i` this cycle; may arrive in the same cycle `mem_req_o` first rises.
- `mem_data_i`  in  32  fetched instruction word.
- `instr_o`  out  32  instruction to IF/ID.
- `pc_o`  out  32  PC of `instr_o`; 0 when `valid_o`=0.
- `valid_o`  out  1  `instr_o`/`pc_o` hold a valid instruction.

## Operation
- Registers: `state`, `pc`, `req_addr`, `kill`, and the output buffer (`instr_o`, `pc_o`, `valid_o`).
- Reset values: `state`=IDLE, `pc`=`RESET_PC`, `req_addr`=`mem_addr_o`=`RESET_PC`, `mem_req_o`=0, `kill`=0, `instr_o`=`NOP_INSTR`, `pc_o`=0, `valid_o`=0.
- IDLE:
  - `mem_req_o`=0.
  - If `start_i`=1, load `req_addr`<=`pc` and go to REQ.
- REQ:
  - `mem_req_o`=1 and `mem_addr_o`=`req_addr`.
  - Without ack: if `branch_i`, then `pc`<=target and `kill`<=1. `req_addr` is unchanged, so the handshake stays stable.
  - Ack with `kill`=1 or `branch_i`=1: discard the data and clear `kill`. If `branch_i`, `pc`<=target. Then `req_addr`<=the new `pc` and stay in REQ.
  - Ack otherwise: `instr_o`<=`mem_data_i`, `pc_o`<=`req_addr`, `valid_o`<=1, go to HOLD.
- HOLD:
  - `mem_req_o`=0.
  - If `branch_i`: `pc`<=target, `req_addr`<=target, `valid_o`<=0, `instr_o`<=`NOP_INSTR`, `pc_o`<=0, go to REQ.
  - Else if `stall_i`=0: IF/ID captures the word at this edge. `pc`<=`pc`+4, `req_addr`<=`pc`+4, `valid_o`<=0, go to REQ.
  - Else: hold all state.
- `branch_i` has priority over `stall_i` in every state.
- `start_i` is ignored outside IDLE.
- `pc`+4 wraps modulo 2^32: 32'hFFFF_FFFC to 0.
- `branch_i` in IDLE updates `pc` only.

## Timing
- Zero-wait memory: REQ with ack in cycle T, so `valid_o`=1 in T+1. If not stalled, REQ again in T+2 with the next address. Best-case throughput is one instruction per 2 cycles.
- Each wait cycle of `mem_ack_i` adds one cycle of latency.
- A branch during an outstanding request costs the remaining wait plus one full re-fetch; the wrong-path word never reaches `valid_o`.
- Branch and ack in the same cycle: the data is discarded and the next request, at the target, is visible in the next cycle.
- `rst_i` low mid-transaction clears all registers immediately, including `mem_req_o` (asynchronous). Memory drops the transaction.
- The first REQ after reset release happens in the cycle after `start_i` is sampled high.

## Test plan
- Reset low then high, `start_i`=1, memory acks immediately with 32'h00500093 -> `mem_addr_o`=0, then `valid_o`=1, `instr_o`=32'h00500093, `pc_o`=0, then next request address 4.
- `stall_i`=1 for 3 cycles while in HOLD -> `instr_o`/`pc_o`/`valid_o` constant, `mem_req_o`=0. After release, the request address is `pc_o`+4.
- Ack delayed 4 cycles, `branch_i`=1 with target 32'h40 in wait cycle 2 -> `mem_addr_o` stays stable until ack, the data is dropped, then a request to 32'h40 follows and `pc_o`=32'h40 on the next valid.
- `branch_i`=1 with target 32'h103 together with ack -> ack data discarded, next `mem_addr_o`=32'h100.
- HOLD with `branch_i` and `stall_i` both 1 -> `valid_o` falls the next cycle, `instr_o`=`NOP_INSTR`, the request goes to the target.
- `RESET_PC`=32'hFFFF_FFFC, two fetches, zero-wait -> addresses FFFF_FFFC then 0. Assert `rst_i` mid-wait -> `mem_req_o` drops immediately and all outputs return to reset values.
